axi_adc_jesd204_pn_checker: RTL and testbench

- Multi-sample, multi-pattern PN/ramp monitor for one ADC channel on the JESD204 ADC data path.
- Adds to the existing per-channel PN monitor: a selectable PRBS/ramp pattern, a programmable lock/unlock hysteresis, valid gating, and an optional saturating error counter.
- Sits beside the data formatter in each channel. Its outputs feed the channel register block, which synchronises them into the up_clk domain.

---
 rtl/axi_adc_jesd204_pn_checker.sv | 235 +++++++++++++++++++++++
 tb/tb_axi_adc_jesd204_pn_checker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_adc_jesd204_pn_checker.sv
`default_nettype none
// ============================================================================
// Module   : axi_adc_jesd204_pn_checker
// Brief    : Per-channel PN9 / PN23 / ramp monitor for the JESD204 ADC data
//            path. It has a two-stage pipeline, OOS/SYNC lock hysteresis,
//            valid gating and an optional saturating error counter.
// Options  : define AXI_ADC_JESD204_PN_ERRCNT_EN to build the error counter;
//            without it adc_pn_err_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module axi_adc_jesd204_pn_checker #(
   parameter int CHANNEL_WIDTH   = 14,
   parameter int DATA_PATH_WIDTH = 2,
   parameter int TWOS_COMPLEMENT = 1,
   parameter int OOS_THRESHOLD   = 16,
   parameter int ERRCNT_WIDTH    = 32
) (
   input  logic                                     adc_clk,
   input  logic                                     adc_rst,
   input  logic                                     adc_valid,
   input  logic [CHANNEL_WIDTH*DATA_PATH_WIDTH-1:0] adc_data,
   input  logic [3:0]                               adc_pnseq_sel,
   input  logic                                     adc_pn_err_count_clr,
   output logic                                     adc_pn_oos,
   output logic                                     adc_pn_err,
   output logic [ERRCNT_WIDTH-1:0]                  adc_pn_err_count
);

   localparam int DW = CHANNEL_WIDTH * DATA_PATH_WIDTH;

   localparam logic [3:0] SEL_PN9  = 4'd0;
   localparam logic [3:0] SEL_PN23 = 4'd1;
   localparam logic [3:0] SEL_RAMP = 4'd2;

   localparam logic [0:0] ST_OOS  = 1'b0;
   localparam logic [0:0] ST_SYNC = 1'b1;

   localparam logic [7:0] THRESH = 8'(OOS_THRESHOLD);

   // Flipping the MSB turns two's complement samples into offset binary.
   localparam logic [CHANNEL_WIDTH-1:0] MSB_FLIP =
      (TWOS_COMPLEMENT != 0) ? {1'b1, {(CHANNEL_WIDTH-1){1'b0}}} : '0;
   localparam logic [CHANNEL_WIDTH-1:0] SMP_ONE = CHANNEL_WIDTH'(1);

   // ------------------------------------------------------------------------
   // Stream helpers. Internally a beat is held in "stream order": the first
   // bit on the wire (sample 0 MSB) sits at bit DW-1, and the most recent bit
   // (last sample LSB) sits at bit 0.
   // ------------------------------------------------------------------------
   function automatic logic [DW-1:0] to_stream(input logic [DW-1:0] raw);
      logic [DW-1:0]            s;
      logic [CHANNEL_WIDTH-1:0] smp;
      s = '0;
      for (int j = 0; j < DATA_PATH_WIDTH; j++) begin
         smp = CHANNEL_WIDTH'(raw >> (j * CHANNEL_WIDTH)) ^ MSB_FLIP;
         s   = (s << CHANNEL_WIDTH) | DW'(smp);
      end
      return s;
   endfunction

   // x^9 + x^5 + 1 : b[n] = b[n-9] ^ b[n-5]. s[0] is always the newest bit.
   function automatic logic [DW-1:0] pn9_next(input logic [DW-1:0] seed);
      logic [DW-1:0] s;
      s = seed;
      for (int i = 0; i < DW; i++) begin
         s = {s[DW-2:0], s[8] ^ s[4]};
      end
      return s;
   endfunction

   // x^23 + x^18 + 1 : b[n] = b[n-23] ^ b[n-18].
   function automatic logic [DW-1:0] pn23_next(input logic [DW-1:0] seed);
      logic [DW-1:0] s;
      s = seed;
      for (int i = 0; i < DW; i++) begin
         s = {s[DW-2:0], s[22] ^ s[17]};
      end
      return s;
   endfunction

   // The ramp continues from the last sample of the seed and wraps modulo
   // 2^CHANNEL_WIDTH.
   function automatic logic [DW-1:0] ramp_next(input logic [DW-1:0] seed);
      logic [DW-1:0]            r;
      logic [CHANNEL_WIDTH-1:0] smp;
      r   = '0;
      smp = seed[CHANNEL_WIDTH-1:0];
      for (int j = 0; j < DATA_PATH_WIDTH; j++) begin
         smp = smp + SMP_ONE;
         r   = (r << CHANNEL_WIDTH) | DW'(smp);
      end
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Signals
   // ------------------------------------------------------------------------
   logic [3:0]    sel_q;
   logic          sel_change;
   logic          mode_en;
   logic          pn_mode;
   logic [DW-1:0] rx_stream;
   logic [DW-1:0] exp_stream;
   logic [DW-1:0] seed;

   logic          valid_s1;
   logic [DW-1:0] data_s1;
   logic [DW-1:0] exp_s1;
   logic          pn_s1;

   logic [0:0]    state;
   logic [7:0]    run_cnt;
   logic          err_q;

   logic          mismatch;
   logic [0:0]    state_n;
   logic [7:0]    run_cnt_n;
   logic          err_n;

   // Input-side decode: stream conversion, expected beat, mode flags
   always_comb begin
      rx_stream  = to_stream(adc_data);
      sel_change = (adc_pnseq_sel != sel_q);
      mode_en    = (adc_pnseq_sel <= SEL_RAMP);
      pn_mode    = (adc_pnseq_sel == SEL_PN9) || (adc_pnseq_sel == SEL_PN23);
      case (adc_pnseq_sel)
         SEL_PN9:  exp_stream = pn9_next(seed);
         SEL_PN23: exp_stream = pn23_next(seed);
         SEL_RAMP: exp_stream = ramp_next(seed);
         default:  exp_stream = '0;
      endcase
   end

   // Stage 1: capture beat and expected beat, advance the seed on valid beats
   always_ff @(posedge adc_clk) begin
      if (adc_rst) begin
         sel_q    <= adc_pnseq_sel;
         valid_s1 <= 1'b0;
         data_s1  <= '0;
         exp_s1   <= '0;
         pn_s1    <= 1'b0;
         seed     <= '0;
      end else begin
         sel_q    <= adc_pnseq_sel;
         // A mode change drops the beat so it is never compared against a
         // pattern it was not generated for.
         valid_s1 <= adc_valid && mode_en && !sel_change;
         if (adc_valid) begin
            data_s1 <= rx_stream;
            exp_s1  <= exp_stream;
            pn_s1   <= pn_mode;
            // Locked: free-run from the prediction so corrupted beats do not
            // poison the sequence. Unlocked: follow the incoming data.
            seed    <= (state == ST_SYNC && !sel_change) ? exp_stream : rx_stream;
         end
      end
   end

   // Stage 2 next-state: compare and run the lock/unlock hysteresis
   always_comb begin
      mismatch  = (data_s1 != exp_s1) || (pn_s1 && (data_s1 == '0));
      state_n   = state;
      run_cnt_n = run_cnt;
      err_n     = 1'b0;
      if (sel_change || !mode_en) begin
         state_n   = ST_OOS;
         run_cnt_n = 8'd0;
      end else if (valid_s1) begin
         if (state == ST_OOS) begin
            if (!mismatch) begin
               if (run_cnt + 8'd1 == THRESH) begin
                  state_n   = ST_SYNC;
                  run_cnt_n = 8'd0;
               end else begin
                  run_cnt_n = run_cnt + 8'd1;
               end
            end else begin
               run_cnt_n = 8'd0;
            end
         end else begin
            if (mismatch) begin
               err_n = 1'b1;
               if (run_cnt + 8'd1 == THRESH) begin
                  state_n   = ST_OOS;
                  run_cnt_n = 8'd0;
               end else begin
                  run_cnt_n = run_cnt + 8'd1;
               end
            end else begin
               run_cnt_n = 8'd0;
            end
         end
      end
   end

   // Stage 2 registers: lock state, run counter and error pulse
   always_ff @(posedge adc_clk) begin
      if (adc_rst) begin
         state   <= ST_OOS;
         run_cnt <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         run_cnt <= run_cnt_n;
         err_q   <= err_n;
      end
   end

   assign adc_pn_oos = (state == ST_OOS);
   assign adc_pn_err = err_q;

`ifdef AXI_ADC_JESD204_PN_ERRCNT_EN
   localparam logic [ERRCNT_WIDTH-1:0] CNT_ONE = ERRCNT_WIDTH'(1);

   logic [ERRCNT_WIDTH-1:0] err_count;

   // Saturating error counter, advanced in step with the adc_pn_err register
   always_ff @(posedge adc_clk) begin
      if (adc_rst || adc_pn_err_count_clr) begin
         err_count <= '0;
      end else if (err_n && (err_count != '1)) begin
         err_count <= err_count + CNT_ONE;
      end
   end

   assign adc_pn_err_count = err_count;
`else
   logic unused_clr;

   assign unused_clr       = adc_pn_err_count_clr;
   assign adc_pn_err_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_adc_jesd204_pn_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_adc_jesd204_pn_checker
// Brief    : Directed bench for axi_adc_jesd204_pn_checker (14-bit samples,
//            two per beat, threshold 16). Expected counter values follow
//            AXI_ADC_JESD204_PN_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_adc_jesd204_pn_checker;

   localparam int CW = 14;
   localparam int DW = 28;
`ifdef AXI_ADC_JESD204_PN_ERRCNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          valid = 1'b0;
   logic [DW-1:0] data  = '0;
   logic [3:0]    sel   = 4'd0;
   logic          clr   = 1'b0;
   logic          oos;
   logic          err;
   logic [31:0]   cnt;

   int n_chk  = 0;
   int n_fail = 0;

   logic [8:0]    h9;
   logic [22:0]   h23;
   logic [CW-1:0] ramp_v;
   logic [DW-1:0] d;

   axi_adc_jesd204_pn_checker #(
      .CHANNEL_WIDTH   (CW),
      .DATA_PATH_WIDTH (2),
      .TWOS_COMPLEMENT (1),
      .OOS_THRESHOLD   (16),
      .ERRCNT_WIDTH    (32)
   ) dut (
      .adc_clk              (clk),
      .adc_rst              (rst),
      .adc_valid            (valid),
      .adc_data             (data),
      .adc_pnseq_sel        (sel),
      .adc_pn_err_count_clr (clr),
      .adc_pn_oos           (oos),
      .adc_pn_err           (err),
      .adc_pn_err_count     (cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] ec(input int n);
      return CNT_EN ? 32'(n) : 32'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic v, input logic [DW-1:0] dv);
      valid = v;
      data  = dv;
      tick();
   endtask

   // Bit-serial reference generators; beats are packed sample 0 first, MSB
   // first, then converted to two's complement by flipping each MSB.
   task automatic next_pn9(output logic [DW-1:0] o);
      logic [CW-1:0] smp;
      logic          nb;
      o = '0;
      for (int s = 0; s < 2; s++) begin
         smp = '0;
         for (int b = 0; b < CW; b++) begin
            nb  = h9[8] ^ h9[4];
            h9  = {h9[7:0], nb};
            smp = {smp[CW-2:0], nb};
         end
         o = o | (DW'(smp ^ 14'h2000) << (s * CW));
      end
   endtask

   task automatic next_pn23(output logic [DW-1:0] o);
      logic [CW-1:0] smp;
      logic          nb;
      o = '0;
      for (int s = 0; s < 2; s++) begin
         smp = '0;
         for (int b = 0; b < CW; b++) begin
            nb  = h23[22] ^ h23[17];
            h23 = {h23[21:0], nb};
            smp = {smp[CW-2:0], nb};
         end
         o = o | (DW'(smp ^ 14'h2000) << (s * CW));
      end
   endtask

   task automatic next_ramp(output logic [DW-1:0] o);
      o      = {ramp_v + 14'd1, ramp_v};
      ramp_v = ramp_v + 14'd2;
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      repeat (3) tick();
      check("rst_oos", oos, 1);
      check("rst_err", err, 0);
      check("rst_cnt", cnt, 0);
      rst = 1'b0;

      // PN9 lock: beat 0 mismatches the zero seed, beats 1..16 lock
      h9 = 9'h1FF;
      for (int k = 0; k < 18; k++) begin
         next_pn9(d);
         send(1'b1, d);
         check("pn9_lock_err", err, 0);
         if (k == 16) check("pn9_oos_before", oos, 1);
         if (k == 17) check("pn9_oos_after", oos, 0);
      end
      for (int k = 0; k < 4; k++) begin
         next_pn9(d);
         send(1'b1, d);
         check("pn9_locked_oos", oos, 0);
         check("pn9_locked_err", err, 0);
      end
      check("pn9_cnt0", cnt, 0);

      // Single bit-3 flip while locked
      next_pn9(d);
      send(1'b1, d ^ 28'h8);
      next_pn9(d);
      send(1'b1, d);
      check("flip_err", err, 1);
      check("flip_oos", oos, 0);
      check("flip_cnt", cnt, ec(1));
      next_pn9(d);
      clr = 1'b1;
      send(1'b1, d);
      clr = 1'b0;
      check("flip_next_err", err, 0);
      check("clr_cnt", cnt, 0);
      next_pn9(d);
      send(1'b1, d);

      // 16 corrupted beats drive the checker out of sync
      for (int j = 0; j < 17; j++) begin
         next_pn9(d);
         send(1'b1, (j < 16) ? (d ^ 28'h8) : d);
         if (j >= 1) begin
            check("burst_err", err, 1);
            check("burst_oos", oos, (j == 16) ? 32'd1 : 32'd0);
         end
      end
      check("burst_cnt", cnt, ec(16));

      // Relock on the continuing stream
      for (int k = 0; k < 20; k++) begin
         next_pn9(d);
         send(1'b1, d);
         check("relock_err", err, 0);
      end
      check("relock_oos", oos, 0);
      check("relock_cnt", cnt, ec(16));

      // Clear coinciding with a new error
      next_pn9(d);
      send(1'b1, d ^ 28'h8);
      next_pn9(d);
      clr = 1'b1;
      send(1'b1, d);
      clr = 1'b0;
      check("clr_hit_err", err, 1);
      check("clr_hit_cnt", cnt, 0);
      next_pn9(d);
      send(1'b1, d);
      check("clr_after_err", err, 0);

      // Mode change drops the corrupted in-flight beat
      next_pn9(d);
      send(1'b1, d ^ 28'h8);
      sel = 4'd2;
      next_pn9(d);
      send(1'b1, d);
      check("selchg_oos", oos, 1);
      check("selchg_err", err, 0);
      check("selchg_cnt", cnt, 0);
      send(1'b0, '0);
      check("selchg_err2", err, 0);

      // PN23 with all-zero data never locks
      sel = 4'd1;
      for (int k = 0; k < 100; k++) begin
         send(1'b1, '0);
         check("zero_oos", oos, 1);
         check("zero_err", err, 0);
      end

      // PN23 stream locks after 16 matching beats
      h23 = 23'h7FFFFF;
      for (int k = 0; k < 18; k++) begin
         next_pn23(d);
         send(1'b1, d);
         check("pn23_err", err, 0);
         if (k == 16) check("pn23_oos_before", oos, 1);
         if (k == 17) check("pn23_oos_after", oos, 0);
      end

      // Ramp with valid every other cycle, wrapping through zero
      sel = 4'd2;
      send(1'b0, '0);
      check("ramp_sel_oos", oos, 1);
      send(1'b1, '0);
      send(1'b0, '0);
      ramp_v = 14'd16380;
      for (int k = 0; k < 20; k++) begin
         next_ramp(d);
         send(1'b1, d);
         send(1'b0, '0);
         check("ramp_err", err, 0);
         if (k == 15) check("ramp_oos_before", oos, 1);
         if (k == 16) check("ramp_oos_after", oos, 0);
      end

      // Ramp error while locked
      next_ramp(d);
      send(1'b1, d ^ 28'h8);
      next_ramp(d);
      send(1'b1, d);
      check("ramp_flip_err", err, 1);
      check("ramp_flip_oos", oos, 0);
      check("ramp_flip_cnt", cnt, ec(1));
      next_ramp(d);
      send(1'b1, d);
      check("ramp_next_err", err, 0);

      // Reset mid-stream overrides the pending error
      next_ramp(d);
      send(1'b1, d ^ 28'h8);
      next_ramp(d);
      rst = 1'b1;
      send(1'b1, d);
      check("midrst_oos", oos, 1);
      check("midrst_err", err, 0);
      check("midrst_cnt", cnt, 0);
      rst = 1'b0;
      send(1'b0, '0);
      check("postrst_oos", oos, 1);
      check("postrst_err", err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
